// File: rtl/udp_frame_packer.sv
// udp_frame_packer: prepends a 42-byte Ethernet/IPv4/UDP header to an 8-bit payload stream.
module udp_frame_packer #(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [47:0] src_mac,
  input  logic [47:0] dst_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] s_len,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        len_err,
  output logic [31:0] frame_cnt
);
  typedef enum logic [1:0] {IDLE, CALC, HEADER, PAYLOAD} state_t;
  state_t state;
  logic [47:0] smac, dmac;
  logic [31:0] sip, dip, sum, f1, f2;
  logic [15:0] sport, dport, len, id, csum, cnt, tot, ulen;
  logic [5:0] idx;
  logic [335:0] hdr;
  logic beat;
  always_comb begin
    tot = len + 16'd28;
    ulen = len + 16'd8;
    sum = 32'h4500 + {16'd0, tot} + {16'd0, id} + 32'h4000 + {16'd0, TTL, 8'h11}
        + {16'd0, sip[31:16]} + {16'd0, sip[15:0]} + {16'd0, dip[31:16]} + {16'd0, dip[15:0]};
    f1 = {16'd0, sum[31:16]} + {16'd0, sum[15:0]};
    f2 = {16'd0, f1[31:16]} + {16'd0, f1[15:0]};
    hdr = {dmac, smac, 16'h0800, 16'h4500, tot, id, 16'h4000, TTL, 8'h11, csum,
           sip, dip, sport, dport, ulen, 16'h0000};
    beat = state == PAYLOAD && s_axis_tvalid && m_axis_tready;
    s_axis_tready = state == PAYLOAD && m_axis_tready;
    m_axis_tvalid = state == HEADER || (state == PAYLOAD && s_axis_tvalid);
    m_axis_tlast = state == PAYLOAD && s_axis_tlast;
    // header byte idx is taken MSB-first from the packed header; idx only moves on a handshake
    m_axis_tdata = state == PAYLOAD ? s_axis_tdata :
                   state == HEADER  ? hdr[{3'd0, 6'd41 - idx, 3'd0} +: 8] : 8'd0;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      id <= ID_INIT;
      len_err <= 1'b0;
      frame_cnt <= '0;
      idx <= '0;
      cnt <= '0;
      csum <= '0;
      len <= '0;
      smac <= '0;
      dmac <= '0;
      sip <= '0;
      dip <= '0;
      sport <= '0;
      dport <= '0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (s_axis_tvalid) begin
          len <= s_len;
          smac <= src_mac;
          dmac <= dst_mac;
          sip <= src_ip;
          dip <= dst_ip;
          sport <= src_port;
          dport <= dst_port;
          state <= CALC;
        end
        CALC: begin
          csum <= ~f2[15:0];
          idx <= '0;
          cnt <= '0;
          state <= HEADER;
        end
        HEADER: if (m_axis_tready) begin
          idx <= idx + 6'd1;
          if (idx == 6'd41) state <= PAYLOAD;
        end
        PAYLOAD: if (beat) begin
          cnt <= cnt + 16'd1;
          if (s_axis_tlast) begin
            len_err <= cnt + 16'd1 != len;
            frame_cnt <= frame_cnt + 32'd1;
            id <= id + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_udp_frame_packer.sv
// tb_udp_frame_packer: scoreboard bench for the UDP framer; a second instance runs with ID_INIT=FFFF.
module tb_udp_frame_packer;
  logic aclk = 0, aresetn = 0;
  logic [47:0] src_mac = 48'h020000000001, dst_mac = 48'h020000000002;
  logic [31:0] src_ip = 32'hC0A8010A, dst_ip = 32'hC0A80114;
  logic [15:0] src_port = 16'd1234, dst_port = 16'd5678, s_len = 0;
  logic [7:0] s_tdata = 0;
  logic s_tvalid = 0, s_tlast = 0, m_tready = 1;
  logic s_tready, m_tvalid, m_tlast, len_err;
  logic [7:0] m_tdata;
  logic [31:0] frame_cnt;
  logic s_tready2, m_tvalid2, m_tlast2, len_err2;
  logic [7:0] m_tdata2;
  logic [31:0] frame_cnt2;
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  logic [7:0] cap[64], cap2[64];
  int b = 0, b2 = 0, last_len = 0, gap = 0, last_gap = 0;
  bit gapping = 0, sb_off = 0, rnd = 0, prev_stall = 0;
  logic [7:0] prev_data = 0;
  logic [15:0] exp_id = 0, exp_id2 = 16'hFFFF;

  udp_frame_packer dut (
    .aclk(aclk), .aresetn(aresetn), .src_mac(src_mac), .dst_mac(dst_mac),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .s_len(s_len), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .len_err(len_err), .frame_cnt(frame_cnt));

  udp_frame_packer #(.ID_INIT(16'hFFFF)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .src_mac(src_mac), .dst_mac(dst_mac),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .s_len(s_len), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata2),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast2),
    .len_err(len_err2), .frame_cnt(frame_cnt2));

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [47:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) q.push_back({1'b0, 8'(v >> (8 * k))});
  endtask

  // expected frame; checksum uses end-around carry after every word
  task automatic push_frame(input logic [15:0] len, input int n);
    logic [15:0] w[10];
    logic [16:0] s;
    s = 0;
    w = '{16'h4500, len + 16'd28, exp_id, 16'h4000, 16'h4011, 16'h0000,
          src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]};
    for (int k = 0; k < 10; k++) begin
      s = {1'b0, s[15:0]} + {1'b0, w[k]};
      s = {1'b0, s[15:0]} + {16'd0, s[16]};
    end
    put(dst_mac, 6); put(src_mac, 6); put(48'h0800, 2); put(48'h4500, 2);
    put({32'd0, len + 16'd28}, 2); put({32'd0, exp_id}, 2); put(48'h4000, 2); put(48'h4011, 2);
    put({32'd0, ~s[15:0]}, 2); put({16'd0, src_ip}, 4); put({16'd0, dst_ip}, 4);
    put({32'd0, src_port}, 2); put({32'd0, dst_port}, 2); put({32'd0, len + 16'd8}, 2); put(48'h0, 2);
    for (int i = 0; i < n; i++) q.push_back({i == n - 1, 8'(i)});
  endtask

  task automatic send(input logic [15:0] len, input int n);
    bit ok;
    int g;
    push_frame(len, n);
    exp_id++;
    s_len = len;
    for (int i = 0; i < n; i++) begin
      s_tdata = 8'(i);
      s_tvalid = 1;
      s_tlast = (i == n - 1);
      g = 0;
      ok = 0;
      while (!ok && g < 500) begin
        #1 ok = s_tready;
        @(negedge aclk);
        g++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got no s_axis_tready expected ready within 500 cycles");
      end
    end
    s_tvalid = 0;
    s_tlast = 0;
    #1;
  endtask

  task automatic do_reset;
    aresetn = 0;
    s_tvalid = 0;
    s_tlast = 0;
    exp_id = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    #1;
  endtask

  initial forever begin
    @(negedge aclk);
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: pops the scoreboard on every output handshake
  initial forever begin
    @(negedge aclk);
    #2;
    if (!aresetn) begin
      b = 0;
      b2 = 0;
      exp_id2 = 16'hFFFF;
      prev_stall = 0;
      gapping = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, prev_data});
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      if (gapping && !m_tvalid) gap++;
      if (gapping && m_tvalid) begin
        last_gap = gap;
        gapping = 0;
      end
      if (m_tvalid && m_tready) begin
        cap[b[5:0]] = m_tdata;
        if (!sb_off) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected no output", m_tdata);
          end else chk("frame_byte", {23'd0, m_tlast, m_tdata}, {23'd0, q.pop_front()});
        end
        b++;
        if (m_tlast) begin
          last_len = b;
          b = 0;
          gapping = 1;
          gap = 0;
        end
      end
      if (m_tvalid2 && m_tready) begin
        cap2[b2[5:0]] = m_tdata2;
        b2++;
        if (m_tlast2) begin
          chk("id_init_ffff", {16'd0, cap2[18], cap2[19]}, {16'd0, exp_id2});
          exp_id2++;
          b2 = 0;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, m_tvalid}, 0);
    chk("rst_tlast", {31'd0, m_tlast}, 0);
    chk("rst_tdata", {24'd0, m_tdata}, 0);
    chk("rst_tready", {31'd0, s_tready}, 0);
    chk("rst_len_err", {31'd0, len_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    aresetn = 1;
    @(negedge aclk);
    #1;

    send(18, 18);
    chk("basic_bytes", last_len, 60);
    chk("basic_total_len", {16'd0, cap[16], cap[17]}, 32'h002E);
    chk("basic_id", {16'd0, cap[18], cap[19]}, 32'h0000);
    chk("basic_csum", {16'd0, cap[24], cap[25]}, 32'hB750);
    chk("basic_udp_len", {16'd0, cap[38], cap[39]}, 32'h001A);
    chk("basic_frame_cnt", frame_cnt, 1);
    chk("basic_len_err", {31'd0, len_err}, 0);

    rnd = 1;
    send(18, 18);
    rnd = 0;
    chk("rnd_bytes", last_len, 60);
    chk("rnd_id", {16'd0, cap[18], cap[19]}, 32'h0001);
    chk("rnd_frame_cnt", frame_cnt, 2);

    do_reset();
    send(4, 4);
    chk("b2b1_id", {16'd0, cap[18], cap[19]}, 32'h0000);
    chk("b2b1_csum", {16'd0, cap[24], cap[25]}, 32'hB75E);
    chk("b2b1_bytes", last_len, 46);
    send(4, 4);
    chk("b2b2_id", {16'd0, cap[18], cap[19]}, 32'h0001);
    chk("b2b2_csum", {16'd0, cap[24], cap[25]}, 32'hB75D);
    chk("b2b_gap", last_gap, 2);
    chk("b2b_frame_cnt", frame_cnt, 2);

    send(10, 8);
    chk("short_bytes", last_len, 50);
    chk("short_len_err", {31'd0, len_err}, 1);
    chk("short_frame_cnt", frame_cnt, 3);
    @(negedge aclk);
    #1;
    chk("short_len_err_pulse", {31'd0, len_err}, 0);

    sb_off = 1;
    s_len = 18;
    s_tdata = 0;
    s_tvalid = 1;
    begin
      int g = 0;
      while (b < 20 && g < 200) begin
        @(negedge aclk);
        #3;
        g++;
      end
      if (b < 20) chk("midrst_reach_byte20", b, 20);
    end
    aresetn = 0;
    #1;
    chk("midrst_tvalid", {31'd0, m_tvalid}, 0);
    chk("midrst_tdata", {24'd0, m_tdata}, 0);
    chk("midrst_tready", {31'd0, s_tready}, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    s_tvalid = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    sb_off = 0;
    exp_id = 0;
    #1;
    send(18, 18);
    chk("post_rst_first", {24'd0, cap[0]}, 32'h02);
    chk("post_rst_id", {16'd0, cap[18], cap[19]}, 32'h0000);
    chk("post_rst_frame_cnt", frame_cnt, 1);

    repeat (3) @(negedge aclk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
